obi_rid_tracker: RTL and testbench

// - Single-channel OBI-to-OBI stage placed directly upstream of the OBI->TCDM converter.
// - Stores the AID of every granted request in an in-order FIFO.
// - Returns that AID as RID on the matching response. The converter returns RID=0, so it

---
 rtl/obi_rid_tracker.sv | 168 ++++++++++++++++
 tb/tb_obi_rid_tracker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rid_tracker.sv
// OBI ID tracker: remembers the AID of every granted request in an in-order
// FIFO and hands it back as RID on the matching response. It sits in front of
// a converter that does not carry IDs. It also limits the number of outstanding
// transactions and flags responses that arrive when nothing is pending.
module obi_rid_tracker #(
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned BeWidth       = DataWidth / 8,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1),
    localparam int unsigned PtrWidth      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // Upstream (slave-side) request
    input  logic                 slv_req_i,
    output logic                 slv_gnt_o,
    input  logic [AddrWidth-1:0] slv_addr_i,
    input  logic                 slv_we_i,
    input  logic [BeWidth-1:0]   slv_be_i,
    input  logic [DataWidth-1:0] slv_wdata_i,
    input  logic [IdWidth-1:0]   slv_aid_i,
    // Upstream (slave-side) response
    output logic                 slv_rvalid_o,
    output logic [DataWidth-1:0] slv_rdata_o,
    output logic [IdWidth-1:0]   slv_rid_o,
    output logic                 slv_err_o,
    // Downstream (master-side) request
    output logic                 mst_req_o,
    input  logic                 mst_gnt_i,
    output logic [AddrWidth-1:0] mst_addr_o,
    output logic                 mst_we_o,
    output logic [BeWidth-1:0]   mst_be_o,
    output logic [DataWidth-1:0] mst_wdata_o,
    // Downstream (master-side) response
    input  logic                 mst_rvalid_i,
    input  logic [DataWidth-1:0] mst_rdata_i,
    input  logic                 mst_err_i,
    // Status
    output logic                 unexp_rsp_o,
    output logic [CntWidth-1:0]  outstanding_o
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IdWidth-1:0]  aid_mem_q [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                unexp_q, unexp_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic unexp_now;

    assign full      = (count_q == CntWidth'(MaxOutstanding));
    assign empty     = (count_q == '0);
    // No bypass: a pop in the same cycle does not free a slot for this cycle's grant.
    assign push      = slv_req_i & mst_gnt_i & ~full;
    // A just-pushed AID cannot be popped in the same cycle, so pop only looks at
    // what was already stored.
    assign pop       = mst_rvalid_i & ~empty;
    assign unexp_now = mst_rvalid_i & empty;

    // ------------------------------------------------------------------------
    // Request path: combinational pass-through, gated by the outstanding cap
    // ------------------------------------------------------------------------
    // Drive downstream request and upstream grant, withheld while full
    always_comb begin
        mst_req_o   = slv_req_i & ~full;
        slv_gnt_o   = mst_gnt_i & ~full;
        mst_addr_o  = slv_addr_i;
        mst_we_o    = slv_we_i;
        mst_be_o    = slv_be_i;
        mst_wdata_o = slv_wdata_i;
    end

    // ------------------------------------------------------------------------
    // Response path: combinational pass-through, RID taken from the FIFO head
    // ------------------------------------------------------------------------
    // Forward the response and attach the oldest tracked AID
    always_comb begin
        slv_rvalid_o = mst_rvalid_i;
        slv_rdata_o  = mst_rdata_i;
        slv_err_o    = mst_err_i;
        slv_rid_o    = empty ? '0 : aid_mem_q[rd_ptr_q];
    end

    // Status outputs straight from state
    always_comb begin
        unexp_rsp_o   = unexp_q;
        outstanding_o = count_q;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Pointer wrap is modulo MaxOutstanding, so non-power-of-two depths work
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(MaxOutstanding - 1)) begin
            return '0;
        end
        return ptr + PtrWidth'(1);
    endfunction

    // Compute pointer, count and sticky-flag updates
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        unexp_d  = unexp_q | unexp_now;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Pointers, count and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            unexp_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            unexp_q  <= unexp_d;
        end
    end

    // AID storage, written at the write pointer on every push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                aid_mem_q[i] <= '0;
            end
        end else if (push) begin
            aid_mem_q[wr_ptr_q] <= slv_aid_i;
        end
    end

    // Simulation-only warning when a response arrives with nothing outstanding
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!unexp_now)
            else $warning("obi_rid_tracker: response received with no outstanding request");
        end
    end

endmodule

// File: tb/tb_obi_rid_tracker.sv
// Self-checking bench for obi_rid_tracker: directed scenarios followed by a
// randomized phase, all compared every cycle against a queue-based model.
module tb_obi_rid_tracker;

    localparam int unsigned IdWidth        = 4;
    localparam int unsigned AddrWidth      = 32;
    localparam int unsigned DataWidth      = 32;
    localparam int unsigned MaxOutstanding = 2;
    localparam int unsigned BeWidth        = DataWidth / 8;
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1);

    logic                 clk_i;
    logic                 rst_ni;
    logic                 slv_req_i;
    logic                 slv_gnt_o;
    logic [AddrWidth-1:0] slv_addr_i;
    logic                 slv_we_i;
    logic [BeWidth-1:0]   slv_be_i;
    logic [DataWidth-1:0] slv_wdata_i;
    logic [IdWidth-1:0]   slv_aid_i;
    logic                 slv_rvalid_o;
    logic [DataWidth-1:0] slv_rdata_o;
    logic [IdWidth-1:0]   slv_rid_o;
    logic                 slv_err_o;
    logic                 mst_req_o;
    logic                 mst_gnt_i;
    logic [AddrWidth-1:0] mst_addr_o;
    logic                 mst_we_o;
    logic [BeWidth-1:0]   mst_be_o;
    logic [DataWidth-1:0] mst_wdata_o;
    logic                 mst_rvalid_i;
    logic [DataWidth-1:0] mst_rdata_i;
    logic                 mst_err_i;
    logic                 unexp_rsp_o;
    logic [CntWidth-1:0]  outstanding_o;

    obi_rid_tracker #(
        .IdWidth        (IdWidth),
        .AddrWidth      (AddrWidth),
        .DataWidth      (DataWidth),
        .MaxOutstanding (MaxOutstanding)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .slv_req_i     (slv_req_i),
        .slv_gnt_o     (slv_gnt_o),
        .slv_addr_i    (slv_addr_i),
        .slv_we_i      (slv_we_i),
        .slv_be_i      (slv_be_i),
        .slv_wdata_i   (slv_wdata_i),
        .slv_aid_i     (slv_aid_i),
        .slv_rvalid_o  (slv_rvalid_o),
        .slv_rdata_o   (slv_rdata_o),
        .slv_rid_o     (slv_rid_o),
        .slv_err_o     (slv_err_o),
        .mst_req_o     (mst_req_o),
        .mst_gnt_i     (mst_gnt_i),
        .mst_addr_o    (mst_addr_o),
        .mst_we_o      (mst_we_o),
        .mst_be_o      (mst_be_o),
        .mst_wdata_o   (mst_wdata_o),
        .mst_rvalid_i  (mst_rvalid_i),
        .mst_rdata_i   (mst_rdata_i),
        .mst_err_i     (mst_err_i),
        .unexp_rsp_o   (unexp_rsp_o),
        .outstanding_o (outstanding_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: pending AIDs in issue order plus the sticky flag
    logic [IdWidth-1:0] model_q [$];
    bit                 model_unexp;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Drive one cycle's worth of control inputs; payload is randomized
    task automatic drive(input logic req, input logic gnt, input logic [IdWidth-1:0] aid,
                         input logic rvalid);
        slv_req_i    = req;
        mst_gnt_i    = gnt;
        slv_aid_i    = aid;
        mst_rvalid_i = rvalid;
        slv_addr_i   = $urandom;
        slv_we_i     = 1'($urandom);
        slv_be_i     = BeWidth'($urandom);
        slv_wdata_i  = $urandom;
        mst_rdata_i  = $urandom;
        mst_err_i    = 1'($urandom);
    endtask

    // Check all outputs for the driven inputs, clock once, then advance the model
    task automatic cycle();
        bit                 m_full;
        bit                 m_push;
        bit                 m_pop;
        logic [IdWidth-1:0] m_rid;
        logic [IdWidth-1:0] tmp;
        #1;
        m_full = (model_q.size() == MaxOutstanding);
        m_push = slv_req_i && mst_gnt_i && !m_full;
        m_pop  = mst_rvalid_i && (model_q.size() != 0);
        m_rid  = (model_q.size() != 0) ? model_q[0] : '0;
        check("gnt",         64'(slv_gnt_o),     64'(mst_gnt_i && !m_full));
        check("mst_req",     64'(mst_req_o),     64'(slv_req_i && !m_full));
        check("rvalid",      64'(slv_rvalid_o),  64'(mst_rvalid_i));
        check("rid",         64'(slv_rid_o),     64'(m_rid));
        check("outstanding", 64'(outstanding_o), 64'(model_q.size()));
        check("unexp",       64'(unexp_rsp_o),   64'(model_unexp));
        check("passthru",
              {mst_addr_o, mst_wdata_o},
              {slv_addr_i, slv_wdata_i});
        check("passthru_ctl",
              64'({mst_we_o, mst_be_o, slv_err_o, slv_rdata_o}),
              64'({slv_we_i, slv_be_i, mst_err_i, mst_rdata_i}));
        @(posedge clk_i);
        #1;
        if (m_pop) tmp = model_q.pop_front();
        if (mst_rvalid_i && !m_pop) model_unexp = 1'b1;
        if (m_push) model_q.push_back(slv_aid_i);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0);
        rst_ni = 1'b0;
        model_unexp = 1'b0;
        #12;
        check("reset_outstanding", 64'(outstanding_o), 64'd0);
        check("reset_unexp",       64'(unexp_rsp_o),   64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Idle cycle: all control outputs read 0
        drive(1'b0, 1'b0, '0, 1'b0);
        cycle();

        // Single read, aid 5, response the following cycle
        drive(1'b1, 1'b1, 4'd5, 1'b0);
        cycle();
        check("single_outstanding_1", 64'(outstanding_o), 64'd1);
        drive(1'b0, 1'b0, '0, 1'b1);
        check("single_rid5", 64'(slv_rid_o), 64'd5);
        cycle();
        check("single_outstanding_0", 64'(outstanding_o), 64'd0);

        // Three back-to-back requests; the third stalls until a slot frees
        drive(1'b1, 1'b1, 4'd1, 1'b0); cycle();
        drive(1'b1, 1'b1, 4'd2, 1'b0); cycle();
        drive(1'b1, 1'b1, 4'd3, 1'b0);
        #1;
        check("full_gnt_withheld", 64'(slv_gnt_o), 64'd0);
        check("full_req_withheld", 64'(mst_req_o), 64'd0);
        cycle();
        // Pop and request together while full: still no grant this cycle
        drive(1'b1, 1'b1, 4'd3, 1'b1);
        #1;
        check("full_pop_no_bypass", 64'(slv_gnt_o), 64'd0);
        check("full_pop_rid1",      64'(slv_rid_o), 64'd1);
        cycle();
        drive(1'b1, 1'b1, 4'd3, 1'b0);
        #1;
        check("gnt_after_pop", 64'(slv_gnt_o), 64'd1);
        cycle();
        drive(1'b0, 1'b0, '0, 1'b1); cycle();
        drive(1'b0, 1'b0, '0, 1'b1); cycle();
        check("drained", 64'(outstanding_o), 64'd0);

        // Sustained push+pop for 20 cycles with wrapping aids
        drive(1'b1, 1'b1, 4'd0, 1'b0); cycle();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b1, IdWidth'(i % 16), 1'b1);
            cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b1); cycle();

        // Response with nothing outstanding: forwarded with rid 0, flag sticks
        drive(1'b0, 1'b0, '0, 1'b1);
        cycle();
        check("unexp_set", 64'(unexp_rsp_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            cycle();
        end

        // Asynchronous reset with two outstanding
        drive(1'b1, 1'b1, 4'd9, 1'b0); cycle();
        drive(1'b1, 1'b1, 4'd10, 1'b0); cycle();
        drive(1'b0, 1'b0, '0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_rst_outstanding", 64'(outstanding_o), 64'd0);
        check("async_rst_unexp",       64'(unexp_rsp_o),   64'd0);
        model_q.delete();
        model_unexp = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1'b1, 1'b1, 4'd7, 1'b0); cycle();
        drive(1'b0, 1'b0, '0, 1'b1);
        #1;
        check("post_rst_rid7", 64'(slv_rid_o), 64'd7);
        cycle();

        // Randomized traffic; responses only when something is pending and
        // address-phase signals held stable while a request waits for grant
        begin
            logic               hold;
            logic [IdWidth-1:0] aid;
            logic [AddrWidth-1:0] addr;
            hold = 1'b0;
            aid  = '0;
            addr = '0;
            for (int i = 0; i < 400; i++) begin
                logic req;
                req = hold ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                if (!hold) aid = IdWidth'($urandom);
                drive(req, 1'($urandom_range(0, 3) != 0), aid,
                      (model_q.size() != 0) && ($urandom_range(0, 2) != 0));
                if (hold) slv_addr_i = addr;
                addr = slv_addr_i;
                #1;
                hold = req && !slv_gnt_o;
                cycle();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
